muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised multi-cycle RV32M/RV64M execution unit for the superscalar core. It sits beside the single-cycle integer ALU as a separate functional unit. It accepts one tagged operation at a time over a valid/ready handshake and returns a tagged result over a second valid/ready handshake. Multiplies run at a fixed configurable latency; divides use an iterative radix-2 algorithm with a fast path for special cases. A flush input squashes the operation in flight.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_STAGES, 2, multiply latency in cycles from accept edge to out_valid (>=1)
TAG_W, 6, width of the ROB/destination tag carried through the unit

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash op in flight and any pending result (synchronous)
in_valid  in  1  request valid
in_ready  out  1  unit can accept; high only in IDLE
in_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_op1  in  XLEN  rs1 value
in_op2  in  XLEN  rs2 value
in_tag  in  TAG_W  tag returned with result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  XLEN  result
out_tag  out  TAG_W  tag of the accepted request

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, counters=0. All internal registers are cleared asynchronously.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready && !flush. Op, operands and tag are latched on that edge (edge E0).
- IDLE->MUL when in_op<4. MUL holds for MUL_STAGES cycles. out_valid rises after edge E_MUL_STAGES (MUL_STAGES=1 means out_valid is high the cycle after accept).
- IDLE->DIV when in_op>=4 and neither special case applies. DIV runs XLEN iterations of restoring division on operand magnitudes; out_valid rises after edge E_(XLEN+1).
- Special divide cases skip DIV (IDLE->DONE directly) and set out_valid after E1:
  - divisor==0: DIV/DIVU return all ones; REM/REMU return the dividend.
  - DIV/REM overflow (dividend = most negative, divisor = -1): DIV returns the most negative value; REM returns 0.
- Signed results: quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1). Negation is applied once at the final step.
- MUL returns the low XLEN bits of the product. MULH uses signed x signed, MULHSU signed op1 x unsigned op2, MULHU unsigned x unsigned, each returning the high XLEN bits of the 2*XLEN product.
- DONE: out_valid=1. out_result and out_tag stay stable until out_valid && out_ready; then DONE->IDLE and in_ready goes high the following cycle. There is no same-cycle back-to-back accept.
- in_ready=0 in MUL, DIV and DONE. in_valid is ignored in those states.
- flush: on any edge with flush=1, state goes to IDLE and out_valid=0 next cycle, regardless of state. An in_valid present on the same edge is not accepted. A result in DONE is dropped even if out_ready=1 on that edge.
- rst_n low mid-operation: immediate return to reset values; no partial result is ever presented.
- out_result and out_tag are don't-care while out_valid=0, but the bench checks them only when valid.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD (-3), tag=5, MUL_STAGES=2 -> out_valid 2 cycles after accept, result 0xFFFFFFEB, tag 5. Then MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- Signed high products: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD after 33 cycles. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with out_valid 1 cycle after accept: DIVU 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and tag stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 next cycle and a new op is accepted.
- Flush/reset: assert flush at DIV iteration 10 -> out_valid never rises, in_ready=1 next cycle. Assert rst_n=0 mid-MUL -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide functional unit.
// It accepts one tagged operation at a time and returns one tagged result.
// Multiplies complete after a fixed MUL_STAGES cycles.
// Divides use XLEN iterations of restoring division on operand magnitudes.
// Divide-by-zero and signed overflow resolve in a single cycle.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The counter must reach both the last multiply stage and the final divide step.
    localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    // Architectural and datapath state.
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_out_result;
    logic [TAG_W-1:0]   r_out_tag;
    logic [2:0]         r_op;
    logic [XLEN-1:0]    r_op1;
    logic [XLEN-1:0]    r_op2;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_dvsr;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_special;

    // Accept-time divide classification, computed from the raw request.
    logic               w_div_signed;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [XLEN-1:0]    w_op1_mag;
    logic [XLEN-1:0]    w_op2_mag;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [XLEN-1:0]    w_spec_res;

    // Restoring divide step and final sign correction.
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_trial;
    logic               w_fits;
    logic [XLEN-1:0]    w_quo_fin;
    logic [XLEN-1:0]    w_rem_fin;
    logic [XLEN-1:0]    w_div_res;

    // Multiply datapath.
    logic               w_mul_s1;
    logic               w_mul_s2;
    logic [2*XLEN-1:0]  w_a_ext;
    logic [2*XLEN-1:0]  w_b_ext;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_mul_res;

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;

    // Classify an incoming divide: signedness, magnitudes and the single-cycle special cases.
    always_comb begin
        w_div_signed = ~in_op[0];
        w_op1_neg    = w_div_signed & in_op1[XLEN-1];
        w_op2_neg    = w_div_signed & in_op2[XLEN-1];
        // Negating the most negative value yields the same bits, which is the correct unsigned magnitude.
        w_op1_mag    = w_op1_neg ? (~in_op1 + 1'b1) : in_op1;
        w_op2_mag    = w_op2_neg ? (~in_op2 + 1'b1) : in_op2;
        w_div_zero   = (in_op2 == '0);
        w_div_ovf    = w_div_signed && (in_op1 == MOST_NEG) && (in_op2 == ALL_ONES);
        w_spec_res   = ALL_ONES;
        if (w_div_zero) begin
            w_spec_res = in_op[1] ? in_op1 : ALL_ONES;
        end else if (w_div_ovf) begin
            w_spec_res = in_op[1] ? '0 : MOST_NEG;
        end
    end

    // One restoring-division step: shift in the next dividend bit and subtract the divisor if it fits.
    always_comb begin
        w_shift   = {r_rem, r_quo[XLEN-1]};
        w_trial   = w_shift - {1'b0, r_dvsr};
        w_fits    = ~w_trial[XLEN];
        w_quo_fin = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        w_rem_fin = r_neg_r ? (~r_rem + 1'b1) : r_rem;
        w_div_res = r_op[1] ? w_rem_fin : w_quo_fin;
    end

    // Full 2*XLEN product with per-operand sign extension chosen by the multiply variant.
    always_comb begin
        w_mul_s1  = (r_op == 3'd1) || (r_op == 3'd2);
        w_mul_s2  = (r_op == 3'd1);
        w_a_ext   = {{XLEN{w_mul_s1 & r_op1[XLEN-1]}}, r_op1};
        w_b_ext   = {{XLEN{w_mul_s2 & r_op2[XLEN-1]}}, r_op2};
        w_prod    = w_a_ext * w_b_ext;
        w_mul_res = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    // Control FSM with registered handshake outputs, plus the divide iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_op         <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dvsr       <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_special    <= 1'b0;
        end else if (flush) begin
            // Squash whatever is in flight, including an unconsumed result.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op       <= in_op;
                        r_op1      <= in_op1;
                        r_op2      <= in_op2;
                        r_out_tag  <= in_tag;
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        if (!in_op[2]) begin
                            r_state <= S_MUL;
                        end else begin
                            // Special cases park their answer in the quotient register and
                            // leave DIV after one cycle without iterating.
                            r_state   <= S_DIV;
                            r_special <= w_div_zero | w_div_ovf;
                            r_quo     <= (w_div_zero | w_div_ovf) ? w_spec_res : w_op1_mag;
                            r_rem     <= '0;
                            r_dvsr    <= w_op2_mag;
                            r_neg_q   <= w_op1_neg ^ w_op2_neg;
                            r_neg_r   <= w_op1_neg;
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt == MUL_LAST) begin
                        r_out_result <= w_mul_res;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_special) begin
                        r_out_result <= r_quo;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (r_cnt == DIV_LAST) begin
                        // Sign correction is applied once, after all iterations.
                        r_out_result <= w_div_res;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_rem <= w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_fits};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_special   <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed vectors, random operations against an
// arithmetic reference model, and hand-written flush/reset/backpressure sequences.
module tb_muldiv_unit;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
    localparam int TAG_W      = 6;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_op1;
    logic [XLEN-1:0]  in_op2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result from the instruction definitions, using 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint p;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return MUL_STAGES;
        if (b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Issue one op (waiting for in_ready), then count edges until out_valid is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag,
                          output logic [31:0] res, output logic [TAG_W-1:0] rtag, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) check("out_valid_timeout", {63'b0, out_valid}, 64'd1);
        res  = out_result;
        rtag = out_tag;
    endtask

    // Verify the full handshake of one op with out_ready held high.
    task automatic do_and_check(input string name, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [TAG_W-1:0] tag,
                                input logic [31:0] exp_res, input int exp_lat);
        logic [31:0]      res;
        logic [TAG_W-1:0] rtag;
        int               lat;
        run_op(op, a, b, tag, res, rtag, lat);
        $display("%s op=%0d a=%h b=%h tag=%0d res=%h exp=%h lat=%0d exp_lat=%0d",
                 name, op, a, b, tag, res, exp_res, lat, exp_lat);
        check({name, "_result"}, {32'b0, res}, {32'b0, exp_res});
        check({name, "_tag"}, {58'b0, rtag}, {58'b0, tag});
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
        check({name, "_ready_after"}, {62'b0, in_ready, out_valid}, 64'b10);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    vec_t vecs [14];

    initial begin
        logic [31:0]      res0;
        logic [TAG_W-1:0] tag0;
        int               lat;
        int               seen;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd100,        32'd0,         32'd100,       1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd4, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
        vecs[13] = '{3'd0, 32'h0001_0000,  32'h0001_0000, 32'd0,         2};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_op1 = '0; in_op2 = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_out_result", {32'b0, out_result}, 64'd0);
        check("reset_out_tag", {58'b0, out_tag}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            do_and_check("vec", vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 5),
                         vecs[i].exp_res, vecs[i].exp_lat);
        end

        // Random operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_and_check("rnd", op, a, b, TAG_W'($urandom), ref_result(op, a, b), ref_lat(op, a, b));
        end

        // Backpressure: result and tag hold while out_ready is low.
        out_ready = 1'b0;
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd33, res0, tag0, lat);
        $display("bp op=3 res=%h tag=%0d lat=%0d", res0, tag0, lat);
        check("bp_result", {32'b0, res0}, 64'hFFFF_FFFE);
        check("bp_tag", {58'b0, tag0}, 64'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold", {out_valid, in_ready, 22'b0, out_tag, out_result},
                  {1'b1, 1'b0, 22'b0, 6'd33, 32'hFFFF_FFFE});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {62'b0, in_ready, out_valid}, 64'b10);
        do_and_check("bp_next", 3'd5, 32'd1000, 32'd10, 6'd34, 32'd100, 33);

        // Flush during divide iteration 10: the result never appears.
        in_valid = 1'b1; in_op = 3'd5; in_op1 = 32'd12345; in_op2 = 32'd11; in_tag = 6'd40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy", {62'b0, in_ready, out_valid}, 64'b00);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_div_idle", {62'b0, in_ready, out_valid}, 64'b10);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // A request on a flush edge is not accepted.
        in_valid = 1'b1; in_op = 3'd0; in_op1 = 32'd3; in_op2 = 32'd4; in_tag = 6'd41;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_no_accept", {62'b0, in_ready, out_valid}, 64'b10);

        // Flush drops a pending result even with out_ready high.
        out_ready = 1'b0;
        run_op(3'd0, 32'd6, 32'd7, 6'd42, res0, tag0, lat);
        check("flush_done_result", {32'b0, res0}, 64'd42);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_drop", {62'b0, in_ready, out_valid}, 64'b10);
        @(posedge clk); #1;
        check("flush_done_stay", {62'b0, in_ready, out_valid}, 64'b10);

        // Asynchronous reset mid-multiply returns outputs to reset values immediately.
        in_valid = 1'b1; in_op = 3'd0; in_op1 = 32'd9; in_op2 = 32'd9; in_tag = 6'd43;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mul", {out_valid, in_ready, 24'b0, out_tag, out_result},
              {1'b0, 1'b1, 24'b0, 6'd0, 32'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_no_partial", 64'(seen), 64'd0);
        do_and_check("after_rst", 3'd1, 32'hFFFF_FFFE, 32'd3, 6'd44, 32'hFFFF_FFFF, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
